// File: rtl/mem_align_pkg.sv
// Shared types and helpers for the misaligned-access splitter.
//   state_e       : controller states (IDLE / ACCESS / RESP)
//   ASIZE_*       : access-size encodings (2^n bytes, 3 is illegal)
//   is_misaligned : access not naturally aligned for its size
//   size_mask     : 32-bit lane mask covering the bytes of an access
package mem_align_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [1:0] ASIZE_BYTE    = 2'd0;
    localparam logic [1:0] ASIZE_HALF    = 2'd1;
    localparam logic [1:0] ASIZE_WORD    = 2'd2;
    localparam logic [1:0] ASIZE_ILLEGAL = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] asize, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (asize)
            ASIZE_HALF: mis = addr_lo[0];
            ASIZE_WORD: mis = (addr_lo != 2'b00);
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] asize);
        logic [31:0] m;
        case (asize)
            ASIZE_BYTE: m = 32'h0000_00FF;
            ASIZE_HALF: m = 32'h0000_FFFF;
            default:    m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_align_splitter.sv
// Request front-end for the byte/halfword/word data RAM.
// Accepts one load/store at a time; aligned accesses go out as one native
// RAM op, misaligned halfword/word accesses become a run of byte ops and
// read bytes are reassembled little-endian. One response per request.
//
//   state  | meaning
//   IDLE   | ready for a request, no RAM activity
//   ACCESS | one RAM op per cycle, op index idx_q runs 0..last_q
//   RESP   | response held until resp_ready
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/ready/we/asize/addr/wdata : request handshake and payload
//   resp_valid/ready/rdata/err     : response handshake and payload
//   mem_re/we/asize/addr/wdata     : RAM command bus
//   mem_rdata, mem_alignerr        : RAM read data and misalignment flag
module mem_align_splitter
    import mem_align_pkg::*;
#(
    parameter int addr_width       = 4,
    parameter bit allow_misaligned = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_asize,
    input  logic [addr_width-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [1:0]            mem_asize,
    output logic [addr_width-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_alignerr
);

    state_e                  state_q, state_d;
    logic                    we_q;
    logic [1:0]              asize_q;
    logic [addr_width-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    byte_mode_q;
    logic [1:0]              last_q;
    logic [1:0]              idx_q;
    logic [31:0]             rbuf_q, rbuf_d;
    logic                    err_q;

    logic                    accept;
    logic                    req_mis;
    logic                    req_reject;
    logic [addr_width-1:0]   op_addr;
    logic [7:0]              op_wbyte;

    assign accept     = req_valid && req_ready;
    assign req_mis    = is_misaligned(req_asize, req_addr[1:0]);
    assign req_reject = (req_asize == ASIZE_ILLEGAL) || (req_mis && !allow_misaligned);

    // Byte-mode address wraps naturally at the bus width.
    assign op_addr  = addr_q + addr_width'(idx_q);
    assign op_wbyte = wdata_q[{idx_q, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_reject ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (idx_q == last_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rbuf_d = rbuf_q;
        if (byte_mode_q) begin
            rbuf_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
        end else begin
            rbuf_d = mem_rdata & size_mask(asize_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            asize_q     <= ASIZE_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_mode_q <= 1'b0;
            last_q      <= 2'd0;
            idx_q       <= 2'd0;
            rbuf_q      <= '0;
            err_q       <= 1'b0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                we_q        <= req_we;
                asize_q     <= req_asize;
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                byte_mode_q <= req_mis && allow_misaligned;
                // last op index = N-1: 1 for split halfwords, 3 for split words
                if (req_mis && allow_misaligned) begin
                    last_q <= (req_asize == ASIZE_HALF) ? 2'd1 : 2'd3;
                end else begin
                    last_q <= 2'd0;
                end
                idx_q  <= 2'd0;
                rbuf_q <= '0;
                err_q  <= req_reject;
            end
        end else if (state_q == ACCESS) begin
            idx_q <= idx_q + 2'd1;
            if (!we_q) begin
                rbuf_q <= rbuf_d;
            end
            // Sticky: a later clean op must not clear an earlier alignerr.
            if (mem_alignerr) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_asize  = ASIZE_BYTE;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
            end
            ACCESS: begin
                mem_re = !we_q;
                mem_we = we_q;
                if (byte_mode_q) begin
                    mem_asize = ASIZE_BYTE;
                    mem_addr  = op_addr;
                    mem_wdata = {24'b0, op_wbyte};
                end else begin
                    mem_asize = asize_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q & size_mask(asize_q);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = we_q ? 32'h0 : rbuf_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_align_splitter.sv
// Self-checking bench for mem_align_splitter: a behavioural RAM, a reference
// byte image, and queues of expected RAM ops and responses.
module tb_mem_align_splitter;

    localparam int AW = 4;

    typedef struct packed {
        logic          we;
        logic [1:0]    asize;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } op_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [1:0]    req_asize;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_re, mem_we, mem_alignerr;
    logic [1:0]    mem_asize;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic          b_req_valid, b_req_ready, b_req_we;
    logic [1:0]    b_req_asize;
    logic [AW-1:0] b_req_addr;
    logic [31:0]   b_req_wdata;
    logic          b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0]   b_resp_rdata;
    logic          b_mem_re, b_mem_we;
    logic [1:0]    b_mem_asize;
    logic [AW-1:0] b_mem_addr;
    logic [31:0]   b_mem_wdata;
    logic [31:0]   b_mem_rdata;
    logic          b_mem_alignerr;
    int            b_mem_pulses = 0;

    assign b_mem_rdata    = 32'hA5A5_A5A5;
    assign b_mem_alignerr = 1'b0;

    mem_align_splitter #(.addr_width(AW), .allow_misaligned(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_asize(req_asize), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_asize(mem_asize),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_alignerr(mem_alignerr)
    );

    mem_align_splitter #(.addr_width(AW), .allow_misaligned(1'b0)) u_dut_strict (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_asize(b_req_asize), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_asize(b_mem_asize),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_alignerr(b_mem_alignerr)
    );

    // RAM model: full 4-byte little-endian read from mem_addr (unmasked, so
    // the DUT has to mask native reads itself), alignerr on misaligned native
    // access or on a chosen poisoned address.
    logic [7:0]    ram [16];
    logic [7:0]    ref_mem [16];
    logic [4:0]    aerr_addr = 5'd16;
    logic [AW-1:0] ra;
    logic          tb_wr_en = 1'b0;
    logic [AW-1:0] tb_wr_addr = '0;
    logic [7:0]    tb_wr_data = '0;

    always_comb begin
        ra           = '0;
        mem_rdata    = '0;
        mem_alignerr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ra = mem_addr + AW'(k);
            mem_rdata[8*k +: 8] = ram[ra];
        end
        if (mem_re || mem_we) begin
            mem_alignerr = (mem_asize == 2'd1 && mem_addr[0]) ||
                           (mem_asize == 2'd2 && mem_addr[1:0] != 2'b00) ||
                           ({1'b0, mem_addr} == aerr_addr);
        end
    end

    always @(posedge clk) begin
        if (tb_wr_en) begin
            ram[tb_wr_addr] <= tb_wr_data;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (k < (1 << mem_asize)) begin
                    ram[AW'(mem_addr + AW'(k))] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    op_t   exp_ops  [$];
    resp_t exp_resp [$];

    always @(negedge clk) begin
        op_t   e;
        resp_t r;
        if (mem_re || mem_we) begin
            if (exp_ops.size() == 0) begin
                chk("mem_op_unexpected", {mem_we, mem_asize, mem_addr}, 64'h0);
            end else begin
                e = exp_ops.pop_front();
                chk("op_we",    mem_we,    e.we);
                chk("op_re",    mem_re,    !e.we);
                chk("op_asize", mem_asize, e.asize);
                chk("op_addr",  mem_addr,  e.addr);
                chk("op_wdata", mem_wdata, e.wdata);
            end
        end
        if (resp_valid && resp_ready) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                r = exp_resp.pop_front();
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("resp_err",   resp_err,   r.err);
            end
        end
        if (b_mem_re || b_mem_we) b_mem_pulses++;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 tb_wr_en = 1'b0;
    endtask

    // Reference model: pushes the expected RAM ops and response, updates
    // the reference byte image and returns the expected latency.
    task automatic expect_req(input logic we, input logic [1:0] asize, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, output int lat);
        resp_t         r;
        op_t           o;
        logic          mis;
        int            n;
        logic [AW-1:0] a;
        logic [31:0]   mask;
        r   = '0;
        mis = (asize == 2'd1 && addr[0]) || (asize == 2'd2 && addr[1:0] != 2'b00);
        n   = 1 << asize;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        if (asize == 2'd3) begin
            r.err = 1'b1;
            lat   = 1;
        end else begin
            if (!mis) begin
                o.we = we; o.asize = asize; o.addr = addr; o.wdata = wdata & mask;
                exp_ops.push_back(o);
                if ({1'b0, addr} == aerr_addr) r.err = 1'b1;
                lat = 2;
            end else begin
                for (int k = 0; k < n; k++) begin
                    a = addr + AW'(k);
                    o.we = we; o.asize = 2'd0; o.addr = a; o.wdata = {24'b0, wdata[8*k +: 8]};
                    exp_ops.push_back(o);
                    if ({1'b0, a} == aerr_addr) r.err = 1'b1;
                end
                lat = n + 1;
            end
            for (int k = 0; k < n; k++) begin
                a = addr + AW'(k);
                if (we) ref_mem[a] = wdata[8*k +: 8];
                else    r.rdata[8*k +: 8] = ref_mem[a];
            end
        end
        exp_resp.push_back(r);
    endtask

    task automatic do_req(input logic we, input logic [1:0] asize, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input int hold);
        int lat_exp;
        int lat;
        int t;
        expect_req(we, asize, addr, wdata, lat_exp);
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_asize = asize; req_addr = addr; req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk("latency", lat, lat_exp);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                if (k == 0) begin
                    req_valid = 1'b1; req_we = 1'b1; req_asize = 2'd0;
                    req_addr = '0; req_wdata = 32'hFFFF_FFFF;
                end
                chk("bp_valid", resp_valid, 1);
                chk("bp_rdata", resp_rdata, exp_resp[0].rdata);
                chk("bp_req_ready", req_ready, 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 req_valid = 1'b0; resp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t o;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_asize = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_asize = '0; b_req_addr = '0; b_req_wdata = '0;
        b_resp_ready = 1'b1;

        for (int a = 0; a < 16; a++) preload(AW'(a), 8'(8'h80 + a));
        preload(4'd4, 8'h44); preload(4'd5, 8'h33); preload(4'd6, 8'h22); preload(4'd7, 8'h11);
        preload(4'd15, 8'h34); preload(4'd0, 8'h12);

        @(posedge clk); #1;
        chk("rst_req_ready",  req_ready,  0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err",   resp_err,   0);
        chk("rst_mem_en",     {mem_re, mem_we}, 0);
        chk("rst_mem_bus",    {mem_asize, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        do_req(1'b0, 2'd2, 4'd4,  32'h0, 0);            // aligned word load
        do_req(1'b1, 2'd2, 4'd5,  32'hAABBCCDD, 0);     // split word store
        do_req(1'b0, 2'd2, 4'd5,  32'h0, 0);            // read it back
        do_req(1'b0, 2'd1, 4'd15, 32'h0, 0);            // halfword wrapping 15 -> 0
        do_req(1'b0, 2'd3, 4'd8,  32'h0, 0);            // illegal size
        do_req(1'b1, 2'd1, 4'd2,  32'hDEADBEEF, 0);     // aligned halfword store
        do_req(1'b0, 2'd0, 4'd3,  32'h0, 0);            // aligned byte load
        aerr_addr = 5'd7;
        do_req(1'b1, 2'd2, 4'd6,  32'h01020304, 0);     // alignerr on 2nd byte op
        do_req(1'b0, 2'd1, 4'd7,  32'h0, 0);
        aerr_addr = 5'd16;
        do_req(1'b0, 2'd2, 4'd8,  32'h0, 5);            // backpressure

        // reset during the 2nd byte op of a split word store
        o.we = 1'b1; o.asize = 2'd0; o.addr = 4'd5; o.wdata = 32'h44;
        exp_ops.push_back(o);
        o.addr = 4'd6; o.wdata = 32'h33;
        exp_ops.push_back(o);
        ref_mem[5] = 8'h44; ref_mem[6] = 8'h33;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_asize = 2'd2; req_addr = 4'd5; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_we",     mem_we,     0);
        chk("abort_mem_re",     mem_re,     0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_req_ready",  req_ready,  0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 0);
        end
        chk("abort_ops_drained", exp_ops.size(), 0);
        do_req(1'b0, 2'd2, 4'd4, 32'h0, 0);

        for (int k = 0; k < 14; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 15)), $urandom, 0);
        end

        // strict instance rejects a misaligned halfword without touching RAM
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_asize = 2'd1; b_req_addr = 4'd1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("strict_resp_valid", b_resp_valid, 1);
        chk("strict_resp_err",   b_resp_err,   1);
        chk("strict_resp_rdata", b_resp_rdata, 0);
        @(negedge clk);
        chk("strict_resp_done",  b_resp_valid, 0);
        chk("strict_no_mem",     b_mem_pulses, 0);

        repeat (3) @(negedge clk);
        chk("ops_left",  exp_ops.size(),  0);
        chk("resp_left", exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_align_splitter.md
Name: mem_align_splitter

Overview:
- Request front-end that sits directly upstream of the byte/halfword/word data RAM and drives its re/we/asize/addr/data bus.
- Accepts one load/store at a time over a valid/ready handshake.
- Aligned accesses go to the RAM as one native access. Misaligned halfword/word accesses become a sequence of byte accesses, and read bytes are reassembled little-endian.
- Returns one response per request, with read data and an error flag.

Parameters:
- addr_width, 4, width of request and memory address buses; address arithmetic wraps modulo 2^addr_width.
- allow_misaligned, 1, 1 splits misaligned accesses into byte accesses; 0 rejects them with resp_err and issues no memory access.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_asize  input  2  access width, 2^n bytes; 3 is illegal.
- req_addr  input  addr_width  byte address.
- req_wdata  input  32  store data, little-endian, low bytes used.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load data, zero-extended; 0 for stores.
- resp_err  output  1  illegal size, rejected misalignment, or memory alignerr seen.
- mem_re  output  1  RAM read enable.
- mem_we  output  1  RAM write enable.
- mem_asize  output  2  RAM access width.
- mem_addr  output  addr_width  RAM byte address.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data; valid combinationally in the same cycle mem_re is high.
- mem_alignerr  input  1  RAM misalignment flag.

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready=0 while rst is high.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_re=0, mem_we=0, mem_asize=0, mem_addr=0, mem_wdata=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1 and all mem enables are 0.
  - On req_valid&&req_ready, latch we, asize, addr and wdata, and clear the read buffer and error flag.
  - Misaligned means: asize==1 with addr[0]=1, or asize==2 with addr[1:0]!=0.
  - asize==3 sets err and goes to RESP with no memory access.
  - A misaligned request with allow_misaligned=0 sets err and goes to RESP with no memory access.
  - An aligned request sets op count N=1 in native mode.
  - A misaligned request with allow_misaligned=1 sets N=2^asize in byte mode.
  - In all non-error cases, go to ACCESS with op index i=0.
- ACCESS, one memory op per cycle:
  - mem_re=!we, mem_we=we.
  - Native mode:
    - mem_asize=asize, mem_addr=addr.
    - mem_wdata=wdata masked to the access width.
    - Read buffer captures mem_rdata masked to the access width.
  - Byte mode:
    - mem_asize=0, mem_addr=addr+i (wraps), mem_wdata={24'b0, wdata byte i}.
    - Read buffer byte i captures mem_rdata[7:0].
  - mem_alignerr=1 in any op cycle sets err sticky; remaining ops still issue.
  - i increments each cycle. After op N-1, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata = read buffer (0 for stores); resp_err = err.
  - Outputs are stable until resp_ready. On resp_valid&&resp_ready, go to IDLE the same edge.
  - req_ready stays 0 in ACCESS and RESP, so there is no overlap.
- Latency, accept edge to first resp_valid cycle:
  - aligned: 2 cycles.
  - misaligned: N+1 cycles (halfword 3, word 5).
  - error: 1 cycle.
- Throughput: one request per (latency+1) cycles when resp_ready is held high.
- Byte-mode writes are not atomic; earlier bytes remain written if a later op flags alignerr.
- Address wrap: byte ops past 2^addr_width-1 continue at 0 with no error.
- Reset mid-operation: at the rst edge, mem enables drop to 0, resp_valid drops, and the transaction is discarded. Bytes already written stay written.
- resp_valid is held under backpressure indefinitely; req_valid is ignored during that time.

Decomposition:
- Package mem_align_pkg:
  - state enum IDLE/ACCESS/RESP.
  - constants ASIZE_BYTE=0, ASIZE_HALF=1, ASIZE_WORD=2, ASIZE_ILLEGAL=3.
  - function is_misaligned(asize, addr[1:0]).
  - function size_mask(asize) returning a 32-bit lane mask.
- No sub-module; op counter, lane steering and byte assembly stay in one flat module.

Test Plan:
- Aligned word load, addr=4, RAM word 0x11223344 -> one cycle with mem_re=1, mem_asize=2, mem_addr=4; resp_rdata=0x11223344, resp_err=0, resp_valid 2 cycles after accept.
- Misaligned word store, addr=5, wdata=0xAABBCCDD -> four cycles with mem_we=1, mem_asize=0, addr 5,6,7,8, mem_wdata[7:0] 0xDD,0xCC,0xBB,0xAA; then a load of the same address returns 0xAABBCCDD.
- Misaligned halfword load, addr=15 with addr_width=4, RAM bytes [15]=0x34, [0]=0x12 -> mem_addr 15 then 0; resp_rdata=0x00001234.
- Illegal size: asize=3 -> no mem_re/mem_we pulse; resp_valid with resp_err=1 one cycle after accept. allow_misaligned=0 with halfword at addr=1 -> same result.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, and a new req_valid is ignored until the handshake completes.
- rst asserted during the 2nd byte op of a word store -> next cycle mem_we=0, resp_valid=0, state IDLE; no response is ever produced for the aborted request.
